// File: rtl/mem_arbiter_pkg.sv
// Shared widths, FSM state encodings and last-served encoding for mem_arbiter.
package mem_arbiter_pkg;
  localparam int MemAddrBus = 32;
  localparam int RegBus     = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } last_t;
endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) single-port memory arbiter with registered command.
// MEM_ARB_RR_EN: round-robin tie-break instead of fixed data-over-fetch priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_re,
  input  logic [MemAddrBus-1:0] i_addr,
  output logic [RegBus-1:0]     i_rdata,
  output logic                  i_busy,
  output logic                  i_done,
  input  logic                  d_re,
  input  logic                  d_we,
  input  logic [MemAddrBus-1:0] d_addr,
  input  logic [RegBus-1:0]     d_wdata,
  input  logic [3:0]            d_sel,
  output logic [RegBus-1:0]     d_rdata,
  output logic                  d_busy,
  output logic                  d_done,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [MemAddrBus-1:0] ram_addr,
  output logic [RegBus-1:0]     ram_wdata,
  output logic [3:0]            ram_sel,
  input  logic [RegBus-1:0]     ram_rdata,
  input  logic                  ram_done
);

  localparam logic [MemAddrBus-1:0] WordMask = {{(MemAddrBus-2){1'b1}}, 2'b00};

  state_t state, next_state;
  logic   ready;
  logic   d_req, fin, arb;
  logic   i_cand, d_cand, pick_d, grant_i, grant_d;

`ifdef MEM_ARB_RR_EN
  last_t  last;
`endif

  assign d_req = d_re | d_we;
  assign fin   = (state != IDLE) && ram_done;
  assign arb   = (state == IDLE) || ram_done;

  // Busy is combinational so it covers the very first request cycle.
  assign i_busy = rst & ~i_done & (i_re  | (state == SERVE_I));
  assign d_busy = rst & ~d_done & (d_req | (state == SERVE_D));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // The requester being completed, or whose done is pulsing, is excluded so it
  // cannot be granted again on a request it still holds from the last transfer.
  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    i_cand     = ready & i_re  & ~i_done & (state != SERVE_I);
    d_cand     = ready & d_req & ~d_done & (state != SERVE_D);
`ifdef MEM_ARB_RR_EN
    pick_d     = d_cand & (~i_cand | (last == LAST_I));
`else
    pick_d     = d_cand;
`endif
    if (arb) begin
      if (pick_d) begin
        next_state = SERVE_D;
        grant_d    = 1'b1;
      end else if (i_cand) begin
        next_state = SERVE_I;
        grant_i    = 1'b1;
      end else begin
        next_state = IDLE;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         last <= LAST_I;
    else if (grant_d) last <= LAST_D;
    else if (grant_i) last <= LAST_I;
  end
`endif

  // ready blocks arbitration on the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready     <= 1'b0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_sel   <= '0;
    end else begin
      ready  <= 1'b1;
      i_done <= fin && (state == SERVE_I);
      d_done <= fin && (state == SERVE_D);
      if (fin && (state == SERVE_I))            i_rdata <= ram_rdata;
      if (fin && (state == SERVE_D) && !ram_we) d_rdata <= ram_rdata;
      if (grant_d) begin
        ram_req   <= 1'b1;
        ram_we    <= d_we;
        ram_addr  <= d_addr;
        ram_wdata <= d_wdata;
        ram_sel   <= d_sel;
      end else if (grant_i) begin
        ram_req   <= 1'b1;
        ram_we    <= 1'b0;
        ram_addr  <= i_addr & WordMask;
        ram_wdata <= '0;
        ram_sel   <= 4'b1111;
      end else if (fin) begin
        ram_req   <= 1'b0;
        ram_we    <= 1'b0;
        ram_addr  <= '0;
        ram_wdata <= '0;
        ram_sel   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; outputs sampled on the falling edge.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_re, d_re, d_we, ram_done;
  logic [31:0] i_addr, d_addr, d_wdata, ram_rdata;
  logic [3:0]  d_sel;
  logic [31:0] i_rdata, d_rdata, ram_addr, ram_wdata;
  logic        i_busy, i_done, d_busy, d_done, ram_req, ram_we;
  logic [3:0]  ram_sel;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_irdata, exp_drdata;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_re(i_re), .i_addr(i_addr), .i_rdata(i_rdata), .i_busy(i_busy), .i_done(i_done),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
    .d_rdata(d_rdata), .d_busy(d_busy), .d_done(d_done),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_sel(ram_sel), .ram_rdata(ram_rdata), .ram_done(ram_done)
  );

  task automatic test_reset();
    rst = 1'b0; i_re = 0; d_re = 0; d_we = 0; ram_done = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_sel = 0; ram_rdata = 0;
    @(negedge clk);
    i_re = 1; i_addr = 32'h1006; d_we = 1;
    #1;
    checks++; if (ram_req !== 1'b0) begin failures++; $display("FAIL rst_ram_req got=%0b exp=0", ram_req); end
    checks++; if (i_busy !== 1'b0 || d_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b%0b exp=00", i_busy, d_busy); end
    checks++; if (i_done !== 1'b0 || d_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b%0b exp=00", i_done, d_done); end
    checks++; if (ram_addr !== 32'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin failures++; $display("FAIL rst_data got=%h/%h/%h exp=0", ram_addr, i_rdata, d_rdata); end
    @(negedge clk);
    rst = 1'b1; d_we = 0;
    @(negedge clk);
    checks++; if (ram_req !== 1'b0) begin failures++; $display("FAIL first_edge_grant got=%0b exp=0", ram_req); end
    checks++; if (i_busy !== 1'b1) begin failures++; $display("FAIL first_edge_busy got=%0b exp=1", i_busy); end
    @(negedge clk);
    checks++; if (ram_req !== 1'b1 || ram_addr !== 32'h1004) begin failures++; $display("FAIL second_edge_grant got=%0b/%h exp=1/00001004", ram_req, ram_addr); end
    rst = 1'b0; i_re = 0;
    #1;
    checks++; if (ram_req !== 1'b0 || ram_addr !== 32'h0) begin failures++; $display("FAIL rst_async got=%0b/%h exp=0/0", ram_req, ram_addr); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_fetch();
    i_re = 1; i_addr = 32'h1006;
    #1;
    checks++; if (i_busy !== 1'b1) begin failures++; $display("FAIL fetch_busy_first got=%0b exp=1", i_busy); end
    @(negedge clk);
    checks++; if (ram_req !== 1'b1 || ram_addr !== 32'h1004 || ram_we !== 1'b0 || ram_sel !== 4'hF)
      begin failures++; $display("FAIL fetch_cmd got=%0b/%h/%0b/%h exp=1/00001004/0/f", ram_req, ram_addr, ram_we, ram_sel); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (i_done !== 1'b0 || i_busy !== 1'b1) begin failures++; $display("FAIL fetch_wait got=%0b/%0b exp=0/1", i_done, i_busy); end
    ram_done = 1; ram_rdata = 32'hDEADBEEF;
    @(negedge clk);
    ram_done = 0; ram_rdata = 32'h0;
    checks++; if (i_done !== 1'b1 || i_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_done got=%0b/%h exp=1/deadbeef", i_done, i_rdata); end
    checks++; if (i_busy !== 1'b0 || ram_req !== 1'b0) begin failures++; $display("FAIL fetch_busy_done got=%0b/%0b exp=0/0", i_busy, ram_req); end
    @(negedge clk);
    checks++; if (ram_req !== 1'b0 || i_done !== 1'b0 || i_rdata !== 32'hDEADBEEF)
      begin failures++; $display("FAIL fetch_no_regrant got=%0b/%0b/%h exp=0/0/deadbeef", ram_req, i_done, i_rdata); end
    i_re = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    i_re = 1; i_addr = 32'h40; d_re = 1; d_addr = 32'h200; d_sel = 4'hF;
    @(negedge clk);
    checks++; if (ram_addr !== 32'h200 || ram_we !== 1'b0 || ram_sel !== 4'hF) begin failures++; $display("FAIL b2b_first got=%h/%0b/%h exp=00000200/0/f", ram_addr, ram_we, ram_sel); end
    checks++; if (d_busy !== 1'b1 || i_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%0b%0b exp=11", d_busy, i_busy); end
    ram_done = 1; ram_rdata = 32'h11112222;
    @(negedge clk);
    ram_done = 0;
    checks++; if (ram_req !== 1'b1 || ram_addr !== 32'h40) begin failures++; $display("FAIL b2b_second got=%0b/%h exp=1/00000040", ram_req, ram_addr); end
    checks++; if (d_done !== 1'b1 || d_rdata !== 32'h11112222 || d_busy !== 1'b0) begin failures++; $display("FAIL b2b_d_done got=%0b/%h/%0b exp=1/11112222/0", d_done, d_rdata, d_busy); end
    d_re = 0;
    ram_done = 1; ram_rdata = 32'h33334444;
    @(negedge clk);
    ram_done = 0;
    checks++; if (i_done !== 1'b1 || i_rdata !== 32'h33334444 || d_done !== 1'b0 || ram_req !== 1'b0)
      begin failures++; $display("FAIL b2b_i_done got=%0b/%h/%0b/%0b exp=1/33334444/0/0", i_done, i_rdata, d_done, ram_req); end
    i_re = 0;
    @(negedge clk);
  endtask

  task automatic test_store();
    d_re = 1; d_we = 1; d_addr = 32'h300; d_sel = 4'b0100; d_wdata = 32'h00AB00AB;
    @(negedge clk);
    checks++; if (ram_req !== 1'b1 || ram_we !== 1'b1 || ram_sel !== 4'b0100 || ram_wdata !== 32'h00AB00AB || ram_addr !== 32'h300)
      begin failures++; $display("FAIL store_cmd got=%0b/%0b/%h/%h/%h exp=1/1/4/00ab00ab/00000300", ram_req, ram_we, ram_sel, ram_wdata, ram_addr); end
    ram_done = 1; ram_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    ram_done = 0;
    checks++; if (d_done !== 1'b1 || d_rdata !== 32'h11112222 || ram_req !== 1'b0)
      begin failures++; $display("FAIL store_done got=%0b/%h/%0b exp=1/11112222/0", d_done, d_rdata, ram_req); end
    d_re = 0; d_we = 0;
    @(negedge clk);
  endtask

  task automatic test_tie();
    logic [31:0] first_addr, second_addr;
    first_addr  = RR ? 32'h80  : 32'h400;
    second_addr = RR ? 32'h400 : 32'h80;
    i_re = 1; i_addr = 32'h80; d_re = 1; d_addr = 32'h400; d_sel = 4'hF;
    @(negedge clk);
    checks++; if (ram_addr !== first_addr) begin failures++; $display("FAIL tie_first got=%h exp=%h", ram_addr, first_addr); end
    ram_done = 1; ram_rdata = 32'h5555AAAA;
    @(negedge clk);
    ram_done = 0;
    checks++; if (ram_req !== 1'b1 || ram_addr !== second_addr) begin failures++; $display("FAIL tie_second got=%0b/%h exp=1/%h", ram_req, ram_addr, second_addr); end
    checks++; if ((RR ? i_done : d_done) !== 1'b1) begin failures++; $display("FAIL tie_first_done got=%0b%0b exp_rr=%0b", i_done, d_done, RR); end
    if (RR) i_re = 0; else d_re = 0;
    ram_done = 1; ram_rdata = 32'h6666BBBB;
    @(negedge clk);
    ram_done = 0;
    checks++; if (ram_req !== 1'b0 || (RR ? d_done : i_done) !== 1'b1) begin failures++; $display("FAIL tie_second_done got=%0b/%0b%0b exp_rr=%0b", ram_req, i_done, d_done, RR); end
    exp_irdata = RR ? 32'h5555AAAA : 32'h6666BBBB;
    exp_drdata = RR ? 32'h6666BBBB : 32'h5555AAAA;
    checks++; if (i_rdata !== exp_irdata || d_rdata !== exp_drdata) begin failures++; $display("FAIL tie_rdata got=%h/%h exp=%h/%h", i_rdata, d_rdata, exp_irdata, exp_drdata); end
    i_re = 0; d_re = 0;
    @(negedge clk);
  endtask

  task automatic test_idle_done();
    ram_done = 1; ram_rdata = 32'h77777777;
    @(negedge clk);
    ram_done = 0;
    checks++; if (i_done !== 1'b0 || d_done !== 1'b0 || ram_req !== 1'b0) begin failures++; $display("FAIL idle_done got=%0b%0b%0b exp=000", i_done, d_done, ram_req); end
    checks++; if (i_rdata !== exp_irdata || d_rdata !== exp_drdata) begin failures++; $display("FAIL idle_rdata got=%h/%h exp=%h/%h", i_rdata, d_rdata, exp_irdata, exp_drdata); end
  endtask

  task automatic test_drop();
    i_re = 1; i_addr = 32'h600;
    @(negedge clk);
    checks++; if (ram_req !== 1'b1 || ram_addr !== 32'h600) begin failures++; $display("FAIL drop_grant got=%0b/%h exp=1/00000600", ram_req, ram_addr); end
    i_re = 0;
    #1;
    checks++; if (i_busy !== 1'b1) begin failures++; $display("FAIL drop_busy got=%0b exp=1", i_busy); end
    @(negedge clk);
    ram_done = 1; ram_rdata = 32'h12345678;
    @(negedge clk);
    ram_done = 0;
    checks++; if (i_done !== 1'b1 || i_rdata !== 32'h12345678) begin failures++; $display("FAIL drop_done got=%0b/%h exp=1/12345678", i_done, i_rdata); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (i_done !== 1'b0 || ram_req !== 1'b0) begin failures++; $display("FAIL drop_after%0d got=%0b/%0b exp=0/0", k, i_done, ram_req); end
    end
  endtask

  task automatic test_reset_mid();
    i_re = 1; i_addr = 32'h700;
    @(negedge clk);
    checks++; if (ram_req !== 1'b1) begin failures++; $display("FAIL mid_grant got=%0b exp=1", ram_req); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ram_req !== 1'b0 || i_busy !== 1'b0 || i_done !== 1'b0 || ram_addr !== 32'h0)
      begin failures++; $display("FAIL mid_reset got=%0b/%0b/%0b/%h exp=0/0/0/0", ram_req, i_busy, i_done, ram_addr); end
    @(negedge clk);
    rst = 1'b1; i_re = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (i_done !== 1'b0 || ram_req !== 1'b0) begin failures++; $display("FAIL mid_after%0d got=%0b/%0b exp=0/0", k, i_done, ram_req); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_back_to_back();
    test_store();
    test_tie();
    test_idle_done();
    test_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be none; widths SHALL come from shared defines (`MemAddrBus` 32, `RegBus` 32).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 i_re  in  1  fetch read request, held until i_done.
REQ-005 i_addr  in  32  fetch word address.
REQ-006 i_rdata  out  32  fetch read data.
REQ-007 i_busy  out  1  fetch request pending or in service.
REQ-008 i_done  out  1  one-cycle fetch completion pulse.
REQ-009 d_re / d_we  in  1 each  data-stage read / write request, held until d_done.
REQ-010 d_addr  in  32; d_wdata  in  32; d_sel  in  4  byte enables.
REQ-011 d_rdata  out  32; d_busy  out  1; d_done  out  1, meanings as on the fetch side.
REQ-012 ram_req  out  1; ram_we  out  1; ram_addr  out  32; ram_wdata  out  32; ram_sel  out  4  memory port command.
REQ-013 ram_rdata  in  32; ram_done  in  1  one-cycle completion from memory.

Function
REQ-014 FSM states SHALL be IDLE, SERVE_I, SERVE_D.
REQ-015 IDLE: on a sampled request, the FSM SHALL enter SERVE_I or SERVE_D; ram_req SHALL assert the following cycle (one-cycle grant latency).
REQ-016 Default priority: data side over fetch when both request in the same cycle.
REQ-017 In SERVE_x, ram_* SHALL hold the registered command of the granted requester until ram_done.
REQ-018 Fetch grant: ram_we=0, ram_sel=4'b1111, ram_addr={i_addr[31:2],2'b00}.
REQ-019 Data grant: ram_we=d_we, ram_sel=d_sel, ram_addr=d_addr, ram_wdata=d_wdata.
REQ-020 On ram_done: x_rdata SHALL register ram_rdata (reads only) and x_done SHALL pulse for exactly one cycle; x_rdata SHALL hold until the next x_done.
REQ-021 The ram_done cycle SHALL arbitrate pending requests with zero bubble: a new SERVE_x is entered directly and ram_req stays high.
REQ-022 x_busy SHALL be high from the first cycle x requests until the cycle before x_done; it SHALL be low during x_done.
REQ-023 A request dropped mid-service SHALL be ignored; the transaction SHALL complete and x_done SHALL still pulse.
REQ-024 d_re and d_we both high SHALL be treated as a write.
REQ-025 ram_done while in IDLE SHALL be ignored.
REQ-026 A requester SHALL NOT be re-granted in the cycle its x_done pulses.

Reset
REQ-027 rst low SHALL force IDLE immediately; all outputs SHALL be 0; any in-flight transaction SHALL be abandoned with no done pulse.
REQ-028 After rst deasserts, the first grant SHALL occur no earlier than the second rising edge.

Configuration
REQ-029 MEM_ARB_RR_EN defined: round-robin arbitration; on a tie, the requester not served last SHALL win, and the last-served flag SHALL reset to "fetch".
REQ-030 MEM_ARB_RR_EN undefined: fixed data-over-fetch priority as in REQ-016.

Structure
REQ-031 FSM state encodings and the last-served encoding SHALL live in the shared defines file.
REQ-032 The design SHALL be a single module; no sub-module.

Verification
REQ-033 Fetch only: i_re=1, i_addr=0x1006, ram_done 3 cycles after ram_req, ram_rdata=0xDEADBEEF -> ram_addr=0x1004, i_done one cycle, i_rdata=0xDEADBEEF.
REQ-034 Simultaneous requests, i_re with d_re at 0x200 -> data served first, then fetch with no idle cycle between; with MEM_ARB_RR_EN, a second tie grants fetch.
REQ-035 Store: d_we=1, d_sel=4'b0100, d_wdata=0x00AB00AB -> ram_we=1, ram_sel=4'b0100, d_done pulses, d_rdata unchanged.
REQ-036 Reset mid-service: rst low two cycles after ram_req -> ram_req=0 immediately, no done pulse, FSM in IDLE.
REQ-037 Request dropped: i_re falls before ram_done -> i_done still pulses once, and no second grant follows.
